// File: rtl/mem_pkg.sv
// Shared definitions for the two-requester memory arbiter: parameter defaults,
// the arbiter-generated status code, FSM state encoding and the round-robin pick rule.
package mem_pkg;

  localparam int unsigned WORDSIZE_DEFAULT          = 8;
  localparam int unsigned MEMORY_ADDR_WIDTH_DEFAULT = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT    = 64;

  localparam logic [1:0] STATUS_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // Both pending: the requester that was not served last wins.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    if (req0 && req1) begin
      return ~last;
    end
    return req1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant selection; purely combinational.
module rr_arb2
  import mem_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    grant = rr_pick(req0, req1, last);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin memory arbiter driving an enable/ready + reset/not-ready handshake.
// Optional watchdog on the ISSUE and CLEAR waits: define MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned WORDSIZE          = WORDSIZE_DEFAULT,
  parameter int unsigned MEMORY_ADDR_WIDTH = MEMORY_ADDR_WIDTH_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES    = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset_n,

  input  logic                         r0_req,
  input  logic                         r0_op,
  input  logic [WORDSIZE-1:0]          r0_addr,
  input  logic [MEMORY_ADDR_WIDTH-1:0] r0_wdata,
  output logic                         r0_done,
  output logic [MEMORY_ADDR_WIDTH-1:0] r0_rdata,
  output logic [1:0]                   r0_status,

  input  logic                         r1_req,
  input  logic                         r1_op,
  input  logic [WORDSIZE-1:0]          r1_addr,
  input  logic [MEMORY_ADDR_WIDTH-1:0] r1_wdata,
  output logic                         r1_done,
  output logic [MEMORY_ADDR_WIDTH-1:0] r1_rdata,
  output logic [1:0]                   r1_status,

  output logic                         mem_en,
  output logic                         mem_reset,
  output logic                         mem_op,
  output logic [WORDSIZE-1:0]          mem_addr,
  output logic [MEMORY_ADDR_WIDTH-1:0] mem_datain,
  input  logic [MEMORY_ADDR_WIDTH-1:0] mem_dataout,
  input  logic [1:0]                   mem_status,
  input  logic                         mem_ready
);

  arb_state_e                   r_state;
  arb_state_e                   w_next_state;

  logic                         w_arb_valid;
  logic                         w_arb_grant;
  logic                         r_grant;
  logic                         r_last;

  logic                         r_op;
  logic [WORDSIZE-1:0]          r_addr;
  logic [MEMORY_ADDR_WIDTH-1:0] r_wdata;

  logic [MEMORY_ADDR_WIDTH-1:0] r_rdata0;
  logic [MEMORY_ADDR_WIDTH-1:0] r_rdata1;
  logic [1:0]                   r_status0;
  logic [1:0]                   r_status1;

  logic                         w_clear;
  logic                         w_wd_expired;
  logic                         w_capture;
  logic                         w_flag_timeout;

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  rr_arb2 u_rr_arb2 (
    .req0  (r0_req),
    .req1  (r1_req),
    .last  (r_last),
    .grant (w_arb_grant),
    .valid (w_arb_valid)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wd_cnt;

  // Restarts on every state change so ISSUE and CLEAR each get a full budget.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wd_cnt <= '0;
    end else if (w_next_state != r_state) begin
      r_wd_cnt <= '0;
    end else if (r_state == ST_ISSUE || r_state == ST_CLEAR) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  assign w_wd_expired = (r_state == ST_ISSUE || r_state == ST_CLEAR) &&
                        (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_wd_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    mem_en       = 1'b0;
    w_clear      = 1'b0;
    r0_done      = 1'b0;
    r1_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_valid) begin
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_en = 1'b1;
        if (mem_ready || w_wd_expired) begin
          w_next_state = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_clear = 1'b1;
        if (!mem_ready || w_wd_expired) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        r0_done      = ~r_grant;
        r1_done      = r_grant;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Held in reset while reset_n is low, released in the same cycle reset_n rises.
  assign mem_reset = ~reset_n | w_clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant <= 1'b0;
      r_last  <= 1'b1;
      r_op    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      if (r_state == ST_IDLE && w_arb_valid) begin
        r_grant <= w_arb_grant;
        r_op    <= w_arb_grant ? r1_op    : r0_op;
        r_addr  <= w_arb_grant ? r1_addr  : r0_addr;
        r_wdata <= w_arb_grant ? r1_wdata : r0_wdata;
      end
      if (r_state == ST_DONE) begin
        r_last <= r_grant;
      end
    end
  end

  assign w_capture      = (r_state == ST_ISSUE) && mem_ready;
  assign w_flag_timeout = w_wd_expired &&
                          (((r_state == ST_ISSUE) && !mem_ready) ||
                           ((r_state == ST_CLEAR) && mem_ready));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_status0 <= '0;
      r_status1 <= '0;
    end else if (w_capture) begin
      if (r_grant) begin
        r_rdata1  <= mem_dataout;
        r_status1 <= mem_status;
      end else begin
        r_rdata0  <= mem_dataout;
        r_status0 <= mem_status;
      end
    end else if (w_flag_timeout) begin
      if (r_grant) begin
        r_status1 <= STATUS_TIMEOUT;
      end else begin
        r_status0 <= STATUS_TIMEOUT;
      end
    end
  end

  assign mem_op     = r_op;
  assign mem_addr   = r_addr;
  assign mem_datain = r_wdata;

  assign r0_rdata   = r_rdata0;
  assign r0_status  = r_status0;
  assign r1_rdata   = r_rdata1;
  assign r1_status  = r_status1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory responder plus a
// scoreboard of expected completions (requester, rdata, status).
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TC = 16;

  typedef struct {
    int            id;
    logic [DW-1:0] rdata;
    logic [1:0]    status;
  } exp_t;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;

  logic          r0_req   = 1'b0;
  logic          r0_op    = 1'b0;
  logic [AW-1:0] r0_addr  = '0;
  logic [DW-1:0] r0_wdata = '0;
  logic          r0_done;
  logic [DW-1:0] r0_rdata;
  logic [1:0]    r0_status;

  logic          r1_req   = 1'b0;
  logic          r1_op    = 1'b0;
  logic [AW-1:0] r1_addr  = '0;
  logic [DW-1:0] r1_wdata = '0;
  logic          r1_done;
  logic [DW-1:0] r1_rdata;
  logic [1:0]    r1_status;

  logic          mem_en;
  logic          mem_reset;
  logic          mem_op;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_datain;
  logic [DW-1:0] mem_dataout = '0;
  logic [1:0]    mem_status  = '0;
  logic          mem_ready   = 1'b0;

  int   errors  = 0;
  int   checks  = 0;
  int   n_done0 = 0;
  int   n_done1 = 0;
  int   mem_lat = 0;
  int   lat_cnt = 0;
  bit   stuck   = 1'b0;
  exp_t exp_q[$];

  logic [DW-1:0] mem_model [256];

  always #5 clk = ~clk;

  mem_arbiter #(
    .WORDSIZE          (AW),
    .MEMORY_ADDR_WIDTH (DW),
    .TIMEOUT_CYCLES    (TC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .r0_req      (r0_req),
    .r0_op       (r0_op),
    .r0_addr     (r0_addr),
    .r0_wdata    (r0_wdata),
    .r0_done     (r0_done),
    .r0_rdata    (r0_rdata),
    .r0_status   (r0_status),
    .r1_req      (r1_req),
    .r1_op       (r1_op),
    .r1_addr     (r1_addr),
    .r1_wdata    (r1_wdata),
    .r1_done     (r1_done),
    .r1_rdata    (r1_rdata),
    .r1_status   (r1_status),
    .mem_en      (mem_en),
    .mem_reset   (mem_reset),
    .mem_op      (mem_op),
    .mem_addr    (mem_addr),
    .mem_datain  (mem_datain),
    .mem_dataout (mem_dataout),
    .mem_status  (mem_status),
    .mem_ready   (mem_ready)
  );

  // Memory responder: answers mem_en after mem_lat extra cycles, drops ready on mem_reset.
  // Status 01 for writes, 10 for reads; writes echo the written data.
  always @(negedge clk) begin
    if (mem_reset) begin
      mem_ready <= 1'b0;
      lat_cnt   <= 0;
    end else if (mem_en && !mem_ready && !stuck) begin
      if (lat_cnt >= mem_lat) begin
        mem_ready  <= 1'b1;
        lat_cnt    <= 0;
        mem_status <= mem_op ? 2'b01 : 2'b10;
        if (mem_op) begin
          mem_model[mem_addr] <= mem_datain;
          mem_dataout         <= mem_datain;
        end else begin
          mem_dataout <= mem_model[mem_addr];
        end
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (r0_done) n_done0++;
    if (r1_done) n_done1++;
  end

  function automatic exp_t mk(input int id, input logic [DW-1:0] d, input logic [1:0] s);
    exp_t e;
    e.id     = id;
    e.rdata  = d;
    e.status = s;
    return e;
  endfunction

  // Waits on negedges for any done pulse; who=-1 if maxc cycles pass first.
  task automatic wait_done(input int start, input int maxc, output int who, output int cyc);
    who = -1;
    cyc = start;
    while (cyc < maxc) begin
      @(negedge clk);
      cyc++;
      if (r0_done || r1_done) begin
        who = r0_done ? 0 : 1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    r0_req  = 1'b0;
    r1_req  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_en, mem_reset} !== 2'b01) begin
      errors++; $display("FAIL rst_mem_ctl: got en/rst=%b expected 01", {mem_en, mem_reset});
    end
    checks++;
    if ({r0_done, r1_done, r0_rdata, r1_rdata, r0_status, r1_status} !== '0) begin
      errors++; $display("FAIL rst_req_outs: got %h expected 0",
                         {r0_done, r1_done, r0_rdata, r1_rdata, r0_status, r1_status});
    end
    checks++;
    if ({mem_op, mem_addr, mem_datain} !== '0) begin
      errors++; $display("FAIL rst_mem_cmd: got %h expected 0", {mem_op, mem_addr, mem_datain});
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (mem_reset !== 1'b0) begin
      errors++; $display("FAIL rst_release: got mem_reset=%b expected 0", mem_reset);
    end
    @(negedge clk);
    checks++;
    if ({mem_en, r0_done, r1_done} !== 3'b000) begin
      errors++; $display("FAIL rst_idle: got en/d0/d1=%b expected 000", {mem_en, r0_done, r1_done});
    end
  endtask

  task automatic test_write_read();
    int   who;
    int   cyc;
    exp_t e;
    @(negedge clk);
    mem_lat  = 0;
    r0_op    = 1'b1;
    r0_addr  = 8'h08;
    r0_wdata = 8'hF0;
    r0_req   = 1'b1;
    exp_q.push_back(mk(0, 8'hF0, 2'b01));
    @(negedge clk);
    checks++;
    if ({mem_en, mem_op, mem_addr, mem_datain} !== {1'b1, 1'b1, 8'h08, 8'hF0}) begin
      errors++; $display("FAIL wr_cmd: got en/op/addr/din=%b/%b/%h/%h expected 1/1/08/f0",
                         mem_en, mem_op, mem_addr, mem_datain);
    end
    // Changing inputs mid-transaction must not disturb the latched command.
    r0_req   = 1'b0;
    r0_op    = 1'b0;
    r0_addr  = 8'h55;
    r0_wdata = 8'h00;
    wait_done(1, 20, who, cyc);
    e = exp_q.pop_front();
    checks++;
    if (who !== e.id) begin
      errors++; $display("FAIL wr_who: got %0d expected %0d", who, e.id);
    end
    checks++;
    if ({r0_rdata, r0_status} !== {e.rdata, e.status}) begin
      errors++; $display("FAIL wr_resp: got rdata/status=%h/%b expected %h/%b",
                         r0_rdata, r0_status, e.rdata, e.status);
    end
    checks++;
    if (cyc !== 3) begin
      errors++; $display("FAIL wr_latency: got %0d expected 3", cyc);
    end
    checks++;
    if ({r1_done, r1_rdata, r1_status} !== '0) begin
      errors++; $display("FAIL wr_r1_untouched: got %h expected 0", {r1_done, r1_rdata, r1_status});
    end
    @(negedge clk);
    checks++;
    if ({r0_done, mem_en} !== 2'b00) begin
      errors++; $display("FAIL wr_pulse_end: got done/en=%b expected 00", {r0_done, mem_en});
    end

    @(negedge clk);
    r1_op   = 1'b0;
    r1_addr = 8'h08;
    r1_req  = 1'b1;
    exp_q.push_back(mk(1, 8'hF0, 2'b10));
    wait_done(0, 20, who, cyc);
    r1_req = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (who !== e.id) begin
      errors++; $display("FAIL rd_who: got %0d expected %0d", who, e.id);
    end
    checks++;
    if ({r1_rdata, r1_status} !== {e.rdata, e.status}) begin
      errors++; $display("FAIL rd_resp: got rdata/status=%h/%b expected %h/%b",
                         r1_rdata, r1_status, e.rdata, e.status);
    end
    checks++;
    if ({r0_rdata, r0_status} !== {8'hF0, 2'b01}) begin
      errors++; $display("FAIL rd_r0_held: got %h/%b expected f0/01", r0_rdata, r0_status);
    end
  endtask

  task automatic test_round_robin();
    int   who;
    int   cyc;
    exp_t e;
    logic [DW-1:0] got_d;
    logic [1:0]    got_s;
    apply_reset();
    mem_lat  = 0;
    r0_op    = 1'b0;
    r0_addr  = 8'h08;
    r1_op    = 1'b1;
    r1_addr  = 8'h30;
    r1_wdata = 8'h3C;
    r0_req   = 1'b1;
    r1_req   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) exp_q.push_back(mk(0, 8'hF0, 2'b10));
      else            exp_q.push_back(mk(1, 8'h3C, 2'b01));
    end
    for (int i = 0; i < 4; i++) begin
      wait_done(0, 20, who, cyc);
      if (i == 3) begin
        r0_req = 1'b0;
        r1_req = 1'b0;
      end
      e = exp_q.pop_front();
      got_d = (e.id == 0) ? r0_rdata  : r1_rdata;
      got_s = (e.id == 0) ? r0_status : r1_status;
      checks++;
      if (who !== e.id) begin
        errors++; $display("FAIL rr_order[%0d]: got requester %0d expected %0d", i, who, e.id);
      end
      checks++;
      if ({got_d, got_s} !== {e.rdata, e.status}) begin
        errors++; $display("FAIL rr_resp[%0d]: got %h/%b expected %h/%b",
                           i, got_d, got_s, e.rdata, e.status);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (mem_en !== 1'b0) begin
      errors++; $display("FAIL rr_quiet: got mem_en=%b expected 0", mem_en);
    end
  endtask

  task automatic test_reset_abort();
    int d0;
    int d1;
    @(negedge clk);
    mem_lat  = 5;
    r0_op    = 1'b1;
    r0_addr  = 8'h40;
    r0_wdata = 8'h77;
    r0_req   = 1'b1;
    d0 = n_done0;
    d1 = n_done1;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_en !== 1'b1) begin
      errors++; $display("FAIL abort_in_issue: got mem_en=%b expected 1", mem_en);
    end
    reset_n = 1'b0;
    r0_req  = 1'b0;
    #1;
    checks++;
    if ({mem_en, mem_reset} !== 2'b01) begin
      errors++; $display("FAIL abort_mem_ctl: got en/rst=%b expected 01", {mem_en, mem_reset});
    end
    checks++;
    if ({r0_rdata, r0_status, mem_op, mem_addr, mem_datain} !== '0) begin
      errors++; $display("FAIL abort_clear: got %h expected 0",
                         {r0_rdata, r0_status, mem_op, mem_addr, mem_datain});
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (mem_reset !== 1'b0) begin
      errors++; $display("FAIL abort_release: got mem_reset=%b expected 0", mem_reset);
    end
    repeat (10) @(negedge clk);
    checks++;
    if ({n_done0, n_done1} !== {d0, d1} || mem_en !== 1'b0) begin
      errors++; $display("FAIL abort_no_done: got done0/done1/en=%0d/%0d/%b expected %0d/%0d/0",
                         n_done0, n_done1, mem_en, d0, d1);
    end
  endtask

  task automatic test_drop_req();
    int   who;
    int   cyc;
    int   d0;
    int   d1;
    exp_t e;
    @(negedge clk);
    mem_lat = 3;
    r1_op   = 1'b0;
    r1_addr = 8'h30;
    r1_req  = 1'b1;
    d0 = n_done0;
    d1 = n_done1;
    exp_q.push_back(mk(1, 8'h3C, 2'b10));
    @(negedge clk);
    r1_req = 1'b0;
    wait_done(1, 30, who, cyc);
    e = exp_q.pop_front();
    checks++;
    if (who !== e.id) begin
      errors++; $display("FAIL drop_who: got %0d expected %0d", who, e.id);
    end
    checks++;
    if ({r1_rdata, r1_status} !== {e.rdata, e.status}) begin
      errors++; $display("FAIL drop_resp: got %h/%b expected %h/%b",
                         r1_rdata, r1_status, e.rdata, e.status);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (n_done1 !== d1 + 1 || n_done0 !== d0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL drop_once: got done1/done0/en=%0d/%0d/%b expected %0d/%0d/0",
                         n_done1, n_done0, mem_en, d1 + 1, d0);
    end
  endtask

  task automatic test_timeout();
    int   who;
    int   cyc;
    exp_t e;
    @(negedge clk);
    mem_lat = 0;
    r0_op   = 1'b0;
    r0_addr = 8'h08;
    r0_req  = 1'b1;
    exp_q.push_back(mk(0, 8'hF0, 2'b10));
    wait_done(0, 20, who, cyc);
    r0_req = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (who !== e.id || {r0_rdata, r0_status} !== {e.rdata, e.status}) begin
      errors++; $display("FAIL to_prep: got who/rdata/status=%0d/%h/%b expected %0d/%h/%b",
                         who, r0_rdata, r0_status, e.id, e.rdata, e.status);
    end

    @(negedge clk);
    stuck  = 1'b1;
    r0_req = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
    exp_q.push_back(mk(0, 8'hF0, mem_pkg::STATUS_TIMEOUT));
`endif
    @(negedge clk);
    r0_req = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    wait_done(1, TC + 20, who, cyc);
    e = exp_q.pop_front();
    checks++;
    if (who !== e.id) begin
      errors++; $display("FAIL to_who: got %0d expected %0d", who, e.id);
    end
    checks++;
    if ({r0_rdata, r0_status} !== {e.rdata, e.status}) begin
      errors++; $display("FAIL to_resp: got %h/%b expected %h/%b",
                         r0_rdata, r0_status, e.rdata, e.status);
    end
    checks++;
    if (cyc !== TC + 2) begin
      errors++; $display("FAIL to_latency: got %0d expected %0d", cyc, TC + 2);
    end
    stuck = 1'b0;
`else
    wait_done(1, 1000, who, cyc);
    checks++;
    if (who !== -1) begin
      errors++; $display("FAIL to_no_done: got done from requester %0d expected none", who);
    end
    checks++;
    if ({mem_en, r0_status} !== {1'b1, 2'b10}) begin
      errors++; $display("FAIL to_waiting: got en/status=%b/%b expected 1/10", mem_en, r0_status);
    end
    apply_reset();
    stuck = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_reset_abort();
    test_drop_req();
    test_timeout();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got simulation time limit expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORDSIZE, default 8, memory address width.
REQ-002 SHALL have parameter MEMORY_ADDR_WIDTH, default 8, memory data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, watchdog limit; used only with MEM_ARB_TIMEOUT_EN.
REQ-004 SHALL have port clk  in  1  single system clock, rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rN_req  in  1  requester N (N=0,1) request, level.
REQ-007 SHALL have port rN_op  in  1  1=write, 0=read.
REQ-008 SHALL have port rN_addr  in  WORDSIZE  request address.
REQ-009 SHALL have port rN_wdata  in  MEMORY_ADDR_WIDTH  write data.
REQ-010 SHALL have port rN_done  out  1  one-cycle completion pulse.
REQ-011 SHALL have port rN_rdata  out  MEMORY_ADDR_WIDTH  read data, held until next completion for N.
REQ-012 SHALL have port rN_status  out  2  status captured at completion.
REQ-013 SHALL have port mem_en  out  1  memory enable.
REQ-014 SHALL have port mem_reset  out  1  memory reset (clears memory ready).
REQ-015 SHALL have ports mem_op  out  1, mem_addr  out  WORDSIZE, mem_datain  out  MEMORY_ADDR_WIDTH: latched command.
REQ-016 SHALL have ports mem_dataout  in  MEMORY_ADDR_WIDTH, mem_status  in  2, mem_ready  in  1: memory response.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, CLEAR, DONE, all state changes on rising clk.
REQ-018 In IDLE, any rN_req high SHALL grant one requester; single request granted directly; both high: requester not served last wins (round-robin).
REQ-019 On grant, op/addr/wdata SHALL be latched; later requester input changes ignored until DONE.
REQ-020 ISSUE: mem_en=1, mem_reset=0, command from latch; on mem_ready=1, capture mem_dataout/mem_status into granted rN_rdata/rN_status, go CLEAR.
REQ-021 CLEAR: mem_en=0, mem_reset=1 until mem_ready=0, then DONE.
REQ-022 DONE: granted rN_done=1 for exactly one cycle, mem_reset=0, update last-served pointer, return IDLE.
REQ-023 Minimum latency: rN_done asserted 3 cycles after grant edge when memory responds in one cycle per phase; no upper bound without timeout.
REQ-024 rN_req dropped mid-transaction SHALL NOT abort; rN_done still pulses.
REQ-025 rN_req still high in IDLE after DONE SHALL be a new request.
REQ-026 Ungranted requester's rdata/status/done SHALL be unchanged.
REQ-027 rN_rdata SHALL update on writes too (memory dataout as returned).

Reset
REQ-028 reset_n low SHALL immediately force IDLE, mem_en=0, mem_reset=1, all rN_done/rN_rdata/rN_status/mem_op/mem_addr/mem_datain=0, last-served=1 (r0 wins first tie).
REQ-029 Reset during ISSUE/CLEAR SHALL abandon transaction with no done pulse; mem_reset=0 first cycle after release.

Configuration
REQ-030 With MEM_ARB_TIMEOUT_EN defined: counter of cycles in ISSUE and in CLEAR (cleared on entry); reaching TIMEOUT_CYCLES in ISSUE SHALL set rN_status=2'b11, rN_rdata unchanged, go CLEAR; in CLEAR SHALL go DONE with status 2'b11.
REQ-031 Without MEM_ARB_TIMEOUT_EN: no counter, unbounded wait, 2'b11 never generated by arbiter.

Structure
REQ-032 Shared package mem_pkg SHALL hold WORDSIZE, MEMORY_ADDR_WIDTH defaults, status code STATUS_TIMEOUT=2'b11, FSM state encoding.
REQ-033 Round-robin grant SHALL be sub-module rr_arb2 (inputs req0, req1, last; output grant index, valid).

Verification
REQ-034 r0 write addr 0x08 data 0xF0 -> mem_en, mem_op=1, mem_addr=0x08, mem_datain=0xF0; one r0_done pulse; r0_status=mem_status.
REQ-035 r1 read addr 0x08 afterwards -> r1_rdata=0xF0, r0 outputs unchanged.
REQ-036 r0,r1 held high through 4 transactions after reset -> grant order 0,1,0,1.
REQ-037 reset_n low during ISSUE -> mem_en=0, mem_reset=1 same cycle; no rN_done.
REQ-038 mem_ready stuck 0, macro on -> r0_done TIMEOUT_CYCLES+2 cycles after grant, r0_status=3; macro off -> no r0_done after 1000 cycles.
REQ-039 r1_req dropped after one ISSUE cycle -> r1_done still pulses once.
